// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder: WIDTH-bit carry chain split into STAGES registered chunks.
// Optional subtract port enabled by defining ADDER_SUB_EN.
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             carry_in,
`ifdef ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CHUNK = WIDTH / STAGES;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; a producer holds its payload stable while valid && !ready.
  logic [STAGES-1:0] st_v;
  logic [WIDTH-1:0]  st_a [STAGES];
  logic [WIDTH-1:0]  st_b [STAGES];
  logic [WIDTH-1:0]  st_s [STAGES];
  logic [STAGES-1:0] st_c;
  logic              st_ovf;

  logic [STAGES-1:0] up_v;
  logic [WIDTH-1:0]  up_a [STAGES];
  logic [WIDTH-1:0]  up_b [STAGES];
  logic [WIDTH-1:0]  up_s [STAGES];
  logic [STAGES-1:0] up_c;

  logic [WIDTH-1:0]  nx_s [STAGES];
  logic [STAGES-1:0] nx_c;
  logic              nx_ovf;
  logic [CHUNK:0]    chunk_sum;
  logic [STAGES:0]   ld;

  logic [WIDTH-1:0]  b_eff;
  logic              c_eff;

  // Subtraction folds into the operands at entry, so it travels with them.
`ifdef ADDER_SUB_EN
  assign b_eff = sub ? ~b_in : b_in;
  assign c_eff = sub ? 1'b1 : carry_in;
`else
  assign b_eff = b_in;
  assign c_eff = carry_in;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_up
    if (k == 0) begin : g_first
      assign up_v[k] = in_valid;
      assign up_a[k] = a_in;
      assign up_b[k] = b_eff;
      assign up_s[k] = '0;
      assign up_c[k] = c_eff;
    end else begin : g_rest
      assign up_v[k] = st_v[k-1];
      assign up_a[k] = st_a[k-1];
      assign up_b[k] = st_b[k-1];
      assign up_s[k] = st_s[k-1];
      assign up_c[k] = st_c[k-1];
    end
  end

  always_comb begin
    chunk_sum = '0;
    nx_c      = '0;
    for (int k = 0; k < STAGES; k++) begin
      chunk_sum = {1'b0, up_a[k][k*CHUNK +: CHUNK]}
                + {1'b0, up_b[k][k*CHUNK +: CHUNK]}
                + {{CHUNK{1'b0}}, up_c[k]};
      nx_s[k] = up_s[k];
      nx_s[k][k*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
      nx_c[k] = chunk_sum[CHUNK];
    end
    // Carry into the MSB is recovered from the MSB sum bit and its operands.
    nx_ovf = up_a[STAGES-1][WIDTH-1] ^ up_b[STAGES-1][WIDTH-1]
           ^ nx_s[STAGES-1][WIDTH-1] ^ nx_c[STAGES-1];
  end

  // A stage may load when it is empty or its occupant moves on this edge.
  always_comb begin
    ld = '0;
    ld[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      ld[k] = !st_v[k] | ld[k+1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_v   <= '0;
      st_c   <= '0;
      st_ovf <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        st_a[k] <= '0;
        st_b[k] <= '0;
        st_s[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ld[k]) begin
          st_v[k] <= up_v[k];
          if (up_v[k]) begin
            st_a[k] <= up_a[k];
            st_b[k] <= up_b[k];
            st_s[k] <= nx_s[k];
            st_c[k] <= nx_c[k];
          end
        end
      end
      if (ld[STAGES-1] && up_v[STAGES-1]) begin
        st_ovf <= nx_ovf;
      end
    end
  end

  assign in_ready  = ld[0];
  assign out_valid = st_v[STAGES-1];
  assign sum       = st_s[STAGES-1];
  assign carry_out = st_c[STAGES-1];
  assign overflow  = st_ovf;

endmodule
